// File: rtl/obs_pair_checker_if.sv
// Left/Right memory-request observation streams feeding obs_pair_checker.
interface obs_pair_checker_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          l_valid;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_data;
  logic          l_fcn;
  logic [2:0]    l_typ;
  logic          r_valid;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic          r_fcn;
  logic [2:0]    r_typ;

  modport master (
    output l_valid, l_addr, l_data, l_fcn, l_typ,
    output r_valid, r_addr, r_data, r_fcn, r_typ
  );

  modport slave (
    input l_valid, l_addr, l_data, l_fcn, l_typ,
    input r_valid, r_addr, r_data, r_fcn, r_typ
  );
endinterface

// File: rtl/obs_pair_checker.sv
// In-order Left/Right observation pair checker with bounded skew buffering.
// Only the leading side is ever buffered; the lagging side pairs immediately
// against the FIFO head. Sticky mismatch/overflow flags park the FSM in FAIL.
module obs_pair_checker #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int CW    = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  obs_pair_checker_if.slave      obs,
  output logic                   mismatch,
  output logic                   overflow,
  output logic                   fail,
  output logic [$clog2(DEPTH):0] skew,
  output logic                   skew_side,
  output logic [CW-1:0]          pairs
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);

  typedef enum logic [1:0] {IDLE, SKEW_L, SKEW_R, FAIL} state_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          fcn;
    logic [2:0]    typ;
  } entry_t;

  state_t        r_state, w_state_nxt;
  entry_t        r_mem [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [PW:0]   r_count;
  logic          r_side, r_mismatch, r_overflow;
  logic [CW-1:0] r_pairs;

  entry_t w_l, w_r, w_head, w_push_e, w_cmp_a, w_cmp_b;
  logic   w_lead, w_lag, w_eq;
  logic   w_push, w_pop, w_cmp, w_ovf_set, w_side_set, w_side_val;

  // Read data is don't-care: data only matters when both entries are writes.
  function automatic logic pair_eq(entry_t a, entry_t b);
    return (a.addr == b.addr) && (a.fcn == b.fcn) && (a.typ == b.typ) &&
           (!(a.fcn && b.fcn) || (a.data == b.data));
  endfunction

  assign w_l    = '{addr: obs.l_addr, data: obs.l_data, fcn: obs.l_fcn, typ: obs.l_typ};
  assign w_r    = '{addr: obs.r_addr, data: obs.r_data, fcn: obs.r_fcn, typ: obs.r_typ};
  assign w_head = r_mem[r_rptr];
  assign w_eq   = pair_eq(w_cmp_a, w_cmp_b);

  // Select leading/lagging side and compare operands from the current state.
  always_comb begin
    w_lead   = 1'b0;
    w_lag    = 1'b0;
    w_push_e = w_l;
    w_cmp_a  = w_l;
    w_cmp_b  = w_r;
    case (r_state)
      SKEW_L: begin
        w_lead   = obs.l_valid;
        w_lag    = obs.r_valid;
        w_push_e = w_l;
        w_cmp_a  = w_head;
        w_cmp_b  = w_r;
      end
      SKEW_R: begin
        w_lead   = obs.r_valid;
        w_lag    = obs.l_valid;
        w_push_e = w_r;
        w_cmp_a  = w_head;
        w_cmp_b  = w_l;
      end
      default: begin
        w_push_e = obs.l_valid ? w_l : w_r;
      end
    endcase
  end

  // Next-state and FIFO/flag control.
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_cmp       = 1'b0;
    w_ovf_set   = 1'b0;
    w_side_set  = 1'b0;
    w_side_val  = 1'b0;
    case (r_state)
      IDLE: begin
        if (obs.l_valid && obs.r_valid) begin
          w_cmp = 1'b1;
        end else if (obs.l_valid) begin
          w_push      = 1'b1;
          w_side_set  = 1'b1;
          w_side_val  = 1'b0;
          w_state_nxt = SKEW_L;
        end else if (obs.r_valid) begin
          w_push      = 1'b1;
          w_side_set  = 1'b1;
          w_side_val  = 1'b1;
          w_state_nxt = SKEW_R;
        end
      end
      SKEW_L, SKEW_R: begin
        if (w_lag) begin
          w_pop = 1'b1;
          w_cmp = 1'b1;
        end
        if (w_lead) begin
          if ((r_count == CNT_FULL) && !w_lag) w_ovf_set = 1'b1;
          else                                 w_push    = 1'b1;
        end
        if (w_lag && !w_lead && (r_count == CNT_ONE)) w_state_nxt = IDLE;
        if (w_ovf_set) w_state_nxt = FAIL;
      end
      default: w_state_nxt = FAIL;
    endcase
    if (w_cmp && !w_eq) w_state_nxt = FAIL;
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     r_state <= IDLE;
    else if (clear) r_state <= IDLE;
    else            r_state <= w_state_nxt;
  end

  // FIFO pointers, occupancy, owner side, sticky flags and retired-pair count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_side     <= 1'b0;
      r_mismatch <= 1'b0;
      r_overflow <= 1'b0;
      r_pairs    <= '0;
    end else if (clear) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_side     <= 1'b0;
      r_mismatch <= 1'b0;
      r_overflow <= 1'b0;
      r_pairs    <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (w_side_set) r_side <= w_side_val;
      if (w_cmp && !w_eq) r_mismatch <= 1'b1;
      if (w_ovf_set) r_overflow <= 1'b1;
      if (w_cmp && (r_pairs != '1)) r_pairs <= r_pairs + CW'(1);
    end
  end

  // FIFO storage; contents are meaningless once the pointers are reset.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= w_push_e;
  end

  assign mismatch  = r_mismatch;
  assign overflow  = r_overflow;
  assign fail      = (r_state == FAIL);
  assign skew      = r_count;
  assign skew_side = r_side;
  assign pairs     = r_pairs;
endmodule

// File: tb/tb_obs_pair_checker.sv
// Self-checking bench: directed scenarios plus random streams against a
// queue-based reference model of the pairing rules.
module tb_obs_pair_checker;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int CW    = 4;
  localparam int PMAX  = (1 << CW) - 1;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic clear = 1'b0;
  logic mismatch, overflow, fail, skew_side;
  logic [$clog2(DEPTH):0] skew;
  logic [CW-1:0] pairs;

  obs_pair_checker_if #(.AW(AW), .DW(DW)) u_if ();

  obs_pair_checker #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .CW(CW)) u_dut (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .obs       (u_if.slave),
    .mismatch  (mismatch),
    .overflow  (overflow),
    .fail      (fail),
    .skew      (skew),
    .skew_side (skew_side),
    .pairs     (pairs)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            fcn;
    logic [2:0]    typ;
  } obs_t;

  obs_t q[$];
  bit   m_side, m_mis, m_ovf;
  int   m_pairs;
  int   n_checks = 0;
  int   n_pass   = 0;

  bit   cur_lv, cur_rv;
  obs_t cur_l, cur_r, z;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic bit same(obs_t a, obs_t b);
    if (a.addr != b.addr || a.fcn != b.fcn || a.typ != b.typ) return 1'b0;
    if (a.fcn && b.fcn && a.data != b.data) return 1'b0;
    return 1'b1;
  endfunction

  function automatic obs_t mk(int unsigned k);
    obs_t e;
    e.addr = 32'h1000 + 4 * k;
    e.data = 3 * k + 1;
    e.fcn  = k[0];
    e.typ  = 3'(k % 8);
    return e;
  endfunction

  task automatic drive(bit lv, obs_t l, bit rv, obs_t r);
    cur_lv = lv; cur_l = l; cur_rv = rv; cur_r = r;
    u_if.l_valid = lv; u_if.l_addr = l.addr; u_if.l_data = l.data;
    u_if.l_fcn = l.fcn; u_if.l_typ = l.typ;
    u_if.r_valid = rv; u_if.r_addr = r.addr; u_if.r_data = r.data;
    u_if.r_fcn = r.fcn; u_if.r_typ = r.typ;
  endtask

  task automatic model_reset();
    q.delete();
    m_side = 0; m_mis = 0; m_ovf = 0; m_pairs = 0;
  endtask

  // One clock of the pairing rules, applied to the currently driven inputs.
  task automatic model_step();
    bit   cmp, lead_v, lag_v;
    obs_t a, b, lead_e;
    cmp = 0;
    if (clear) begin
      model_reset();
    end else if (!(m_mis || m_ovf)) begin
      if (q.size() == 0) begin
        if (cur_lv && cur_rv) begin cmp = 1; a = cur_l; b = cur_r; end
        else if (cur_lv) begin q.push_back(cur_l); m_side = 0; end
        else if (cur_rv) begin q.push_back(cur_r); m_side = 1; end
      end else begin
        lead_v = m_side ? cur_rv : cur_lv;
        lag_v  = m_side ? cur_lv : cur_rv;
        lead_e = m_side ? cur_r : cur_l;
        if (lag_v) begin
          cmp = 1;
          a = q.pop_front();
          b = m_side ? cur_l : cur_r;
        end
        if (lead_v) begin
          if (q.size() == DEPTH) m_ovf = 1;
          else q.push_back(lead_e);
        end
      end
      if (cmp) begin
        if (m_pairs < PMAX) m_pairs++;
        if (!same(a, b)) m_mis = 1;
      end
    end
  endtask

  task automatic check_outputs();
    check("mismatch", mismatch, m_mis);
    check("overflow", overflow, m_ovf);
    check("fail", fail, m_mis | m_ovf);
    check("skew", skew, q.size());
    if (q.size() > 0) check("skew_side", skew_side, m_side);
    check("pairs", pairs, m_pairs);
  endtask

  task automatic step();
    model_step();
    @(posedge clock);
    #1;
    check_outputs();
  endtask

  task automatic do_clear();
    clear = 1;
    drive(0, z, 0, z);
    step();
    clear = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_skew [6];
    obs_t e, a, b;
    int unsigned nl, nr;
    bit lv, rv;

    z = '{addr: '0, data: '0, fcn: 0, typ: '0};
    drive(0, z, 0, z);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_outputs();
    reset = 1;

    // Lockstep identical writes.
    for (int i = 0; i < 10; i++) begin
      e = '{addr: 32'h1000 + 4 * i, data: i, fcn: 1, typ: 3'd2};
      drive(1, e, 1, e);
      step();
    end
    check("lockstep_pairs", pairs, 10);
    check("lockstep_skew", skew, 0);
    do_clear();

    // Left leads by three.
    exp_skew = '{1, 2, 3, 2, 1, 0};
    for (int i = 0; i < 6; i++) begin
      if (i < 3) drive(1, mk(i), 0, z);
      else       drive(0, z, 1, mk(i - 3));
      step();
      check("lead3_skew", skew, exp_skew[i]);
      if (i < 5) check("lead3_side", skew_side, 0);
    end
    check("lead3_pairs", pairs, 3);
    check("lead3_mismatch", mismatch, 0);
    do_clear();

    // Overflow on the fifth unmatched Left entry, then valids are ignored.
    for (int i = 0; i < 5; i++) begin
      drive(1, mk(i), 0, z);
      step();
    end
    check("ovf_flag", overflow, 1);
    check("ovf_fail", fail, 1);
    check("ovf_skew", skew, 4);
    for (int i = 0; i < 3; i++) begin
      drive(1, mk(i), 1, mk(i));
      step();
    end
    check("ovf_hold_skew", skew, 4);
    check("ovf_hold_pairs", pairs, 0);
    do_clear();

    // Address difference is a mismatch; read-data difference is not.
    a = '{addr: 32'h20, data: 1, fcn: 1, typ: 3'd0};
    b = a; b.addr = 32'h24;
    drive(1, a, 1, b);
    step();
    check("addr_mismatch", mismatch, 1);
    do_clear();
    a = '{addr: 32'h40, data: 1, fcn: 0, typ: 3'd1};
    b = a; b.data = 2;
    drive(1, a, 1, b);
    step();
    check("read_data_ignored", mismatch, 0);
    do_clear();

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 4; i++) begin
      drive(1, mk(i), 0, z);
      step();
    end
    drive(1, mk(4), 1, mk(0));
    step();
    check("full_pushpop_skew", skew, 4);
    check("full_pushpop_ovf", overflow, 0);
    check("full_pushpop_pairs", pairs, 1);
    do_clear();

    // Asynchronous reset mid-skew.
    drive(1, mk(0), 1, mk(0));
    step();
    for (int i = 0; i < 2; i++) begin
      drive(1, mk(i), 0, z);
      step();
    end
    check("pre_reset_skew", skew, 2);
    #2 reset = 0;
    #1;
    check("async_rst_skew", skew, 0);
    check("async_rst_pairs", pairs, 0);
    check("async_rst_flags", {mismatch, overflow, fail, skew_side}, 0);
    model_reset();
    drive(0, z, 0, z);
    @(posedge clock);
    #1 reset = 1;
    step();

    // Clear out of FAIL.
    a = mk(3); b = a; b.typ = a.typ ^ 3'd1;
    drive(1, a, 1, b);
    step();
    check("fail_before_clear", fail, 1);
    do_clear();
    check("clear_fail", fail, 0);
    check("clear_mismatch", mismatch, 0);
    drive(1, mk(5), 0, z);
    step();
    check("post_clear_accepts", skew, 1);
    do_clear();

    // Random streams with occasional corruption and restarts.
    nl = 0; nr = 0;
    for (int c = 0; c < 800; c++) begin
      lv = ($urandom % 2) == 1;
      rv = ($urandom % 2) == 1;
      a = mk(nl);
      b = mk(nr);
      if ($urandom % 40 == 0) b.addr = b.addr ^ 32'h4;
      if ($urandom % 20 == 0) b.data = b.data ^ 32'h1;
      if (lv) nl++;
      if (rv) nr++;
      clear = (fail && ($urandom % 4 == 0)) || ($urandom % 150 == 0);
      if (clear) begin nl = 0; nr = 0; end
      drive(lv, a, rv, b);
      step();
      clear = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
